hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//   Sequences the 3-LED hazard-light pattern from a fast clock: prescales clk to a step
//   rate, synchronises switches sw1/sw0, selects mode, steps pattern state machine.
//   Sits between the board top (clk from clock divider or CLOCK_50, reset from KEY[0],
//   switches from SW[1:0]) and LEDR[2:0]; replaces per-clock free-running stepping.
// PARAMETERS
//   TICK_DIV  25_000_000  clk cycles per pattern step (>=1); bench uses 4
//   TICK_W    $clog2(TICK_DIV+1)  prescaler width (derived, do not override)
// PORTS
//   clk     in   1  single clock; all state on posedge clk
//   reset   in   1  asynchronous, active-low reset (0 = in reset)
//   enable  in   1  1 = run; 0 = freeze prescaler, state and out
//   sw1     in   1  mode select MSB (asynchronous to clk)
//   sw0     in   1  mode select LSB (asynchronous to clk)
//   out     out  3  LED pattern, out[2] = leftmost LED
//   mode    out  2  mode currently displayed: 00 CALM, 01 RIGHT, 10 LEFT
//   step    out  1  one-clk pulse marking a pattern step
// BEHAVIOUR
//   Reset (reset==0, async, effective immediately, incl. mid-pattern): out=000, mode=00,
//     step=0, prescaler=0, state=IDLE, both synchroniser stages cleared to 0.
//   Sync: sw1/sw0 each pass 2 flops; req = {sw1_s,sw0_s} valid 2 clks after input edge.
//   Prescaler: cnt counts 0..TICK_DIV-1 while enable, wraps to 0. step is combinational
//     = enable && cnt==TICK_DIV-1. TICK_DIV==1 -> step high every enabled cycle.
//     enable==0: cnt, state, out, mode hold; step=0.
//   Requested mode: req 00->CALM, 01->RIGHT, 10->LEFT, 11->keep current mode
//     (11 while in IDLE -> CALM).
//   FSM (advances only on edges where step==1; out/mode are Moore, registered):
//     IDLE out 000 -> first state of requested mode
//     CALM:  C_A 101 -> C_B 010 -> C_A ...
//     RIGHT: R_0 100 -> R_1 010 -> R_2 001 -> R_0 ...
//     LEFT:  L_0 001 -> L_1 010 -> L_2 100 -> L_0 ...
//     Requested mode == current: advance within mode, wrap as above.
//     Requested mode != current: jump to first state (C_A/R_0/L_0) of new mode; never
//       finish old sequence. mode output updates on same edge as state.
//   Latency: out/mode change on the clk edge ending a step cycle; sw edge to out
//     <= 2 + TICK_DIV clks.
//   Switch change between steps: only value sampled on step edge matters (glitches ignored).
//   Enable deassert on step cycle: step=0, no advance. Reasserting resumes from held cnt.
//   No illegal state reachable; default branch -> IDLE, out=000.
// STRUCTURE
//   hazard_pkg: typedef enum logic [3:0] state_t {IDLE,C_A,C_B,R_0,R_1,R_2,L_0,L_1,L_2};
//     typedef enum logic [1:0] mode_t {CALM=2'b00,RIGHT=2'b01,LEFT=2'b10};
//     localparam pattern constants PAT_101, PAT_010, PAT_100, PAT_001.
//   Sub-module tick_gen #(TICK_DIV): clk, reset, enable -> step (prescaler only).
//   Top: synchroniser, mode resolve, state register, output decode.
// TESTING (TICK_DIV=4, sw changes >=2 clks before intended step)
//   1 reset low mid-RIGHT pattern -> out=000, mode=00, step=0 same cycle, no clk needed.
//   2 sw=00 from reset -> out 101,010,101,010 on successive steps; step every 4th clk.
//   3 sw=01 -> 100,010,001,100; switch to 10 while out=010 -> next step 001 (L_0), mode=10.
//   4 sw=11 while RIGHT at R_1 -> continues 001,100; sw=11 out of reset -> CALM 101.
//   5 enable=0 for 10 clks during LEFT at L_1 (010) -> out/mode/cnt frozen, step=0;
//     re-enable -> 100 after remaining cnt cycles.
//   6 TICK_DIV=1 build, sw=10 -> out 001,010,100,001 every clk; step constantly 1.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the hazard-light sequencer.
//   state_t    : pattern state machine encoding (IDLE plus three patterns)
//   mode_t     : displayed mode, the encoding matches the switch request
//   PAT_*      : LED patterns, bit 2 is the leftmost LED
//   firstState : entry state of a mode
//   patternOf  : Moore output decode of a state
package hazard_pkg;

  typedef enum logic [3:0] {
    IDLE,
    C_A,
    C_B,
    R_0,
    R_1,
    R_2,
    L_0,
    L_1,
    L_2
  } state_t;

  typedef enum logic [1:0] {
    CALM  = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10
  } mode_t;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_101 = 3'b101;
  localparam logic [2:0] PAT_010 = 3'b010;
  localparam logic [2:0] PAT_100 = 3'b100;
  localparam logic [2:0] PAT_001 = 3'b001;

  // Entry state used whenever a mode is (re)entered.
  function automatic state_t firstState(input mode_t m);
    case (m)
      CALM:    firstState = C_A;
      RIGHT:   firstState = R_0;
      LEFT:    firstState = L_0;
      default: firstState = C_A;
    endcase
  endfunction

  // LED pattern shown while sitting in a given state.
  function automatic logic [2:0] patternOf(input state_t s);
    case (s)
      C_A:     patternOf = PAT_101;
      C_B:     patternOf = PAT_010;
      R_0:     patternOf = PAT_100;
      R_1:     patternOf = PAT_010;
      R_2:     patternOf = PAT_001;
      L_0:     patternOf = PAT_001;
      L_1:     patternOf = PAT_010;
      L_2:     patternOf = PAT_100;
      default: patternOf = PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// Prescaler that turns the fast clock into a one-cycle step strobe.
//   clk    : in  clock
//   reset  : in  asynchronous active-low reset
//   enable : in  1 = count, 0 = hold the count and suppress step
//   step   : out high on the last cycle of each TICK_DIV-cycle period
module tick_gen #(
  parameter int TICK_DIV = 25_000_000,
  localparam int TICK_W = $clog2(TICK_DIV + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic step
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;
  logic              lastCnt;

  // With TICK_DIV == 1 the count never leaves zero, so lastCnt is always true.
  assign lastCnt = (cnt_q == TICK_W'(TICK_DIV - 1));
  assign step    = enable && lastCnt;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = lastCnt ? '0 : cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Steps a three-LED hazard pattern once per prescaled step, following the
// mode requested on two asynchronous switches.
//   clk    : in  clock, all state on its rising edge
//   reset  : in  asynchronous active-low reset
//   enable : in  1 = run, 0 = freeze prescaler, state and outputs
//   sw1    : in  mode request MSB (asynchronous)
//   sw0    : in  mode request LSB (asynchronous)
//   out    : out LED pattern, out[2] is the leftmost LED
//   mode   : out mode being displayed (00 CALM, 01 RIGHT, 10 LEFT)
//   step   : out one-cycle pulse marking a pattern step
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sw1,
  input  logic       sw0,
  output logic [2:0] out,
  output logic [1:0] mode,
  output logic       step
);

  logic [1:0] swMeta_q;
  logic [1:0] swSync_q;
  logic       stepW;
  state_t     state_q;
  state_t     state_d;
  mode_t      mode_q;
  mode_t      mode_d;
  logic [2:0] out_q;
  logic [2:0] out_d;
  mode_t      reqMode;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) uTickGen (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .step  (stepW)
  );

  assign step = stepW;
  assign out  = out_q;
  assign mode = mode_q;

  // Two-flop synchroniser per switch; both stages clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swMeta_q <= 2'b00;
      swSync_q <= 2'b00;
    end else begin
      swMeta_q <= {sw1, sw0};
      swSync_q <= swMeta_q;
    end
  end

  // Request 11 means "stay in the current mode"; from IDLE there is no
  // current pattern yet, so it falls back to CALM.
  always_comb begin
    reqMode = mode_q;
    case (swSync_q)
      2'b00:   reqMode = CALM;
      2'b01:   reqMode = RIGHT;
      2'b10:   reqMode = LEFT;
      default: reqMode = (state_q == IDLE) ? CALM : mode_q;
    endcase
  end

  // Next state only moves on a step. A mode change jumps straight to the
  // new mode's first state rather than finishing the old sequence.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    out_d   = out_q;
    if (stepW) begin
      if (state_q == IDLE || reqMode != mode_q) begin
        state_d = firstState(reqMode);
      end else begin
        case (state_q)
          C_A:     state_d = C_B;
          C_B:     state_d = C_A;
          R_0:     state_d = R_1;
          R_1:     state_d = R_2;
          R_2:     state_d = R_0;
          L_0:     state_d = L_1;
          L_1:     state_d = L_2;
          L_2:     state_d = L_0;
          default: state_d = IDLE;
        endcase
      end
      mode_d = reqMode;
      out_d  = patternOf(state_d);
    end
  end

  // Pattern and mode are registered together so they change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= CALM;
      out_q   <= PAT_OFF;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
// Directed bench for hazard_sequencer: a TICK_DIV=4 instance driven from a
// vector table plus hand-written reset sequences, and a TICK_DIV=1 instance
// checking the every-cycle stepping case.
module tb_hazard_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       sw1;
  logic       sw0;
  logic [2:0] out;
  logic [1:0] mode;
  logic       step;

  logic       resetB;
  logic       enableB;
  logic       sw1B;
  logic       sw0B;
  logic [2:0] outB;
  logic [1:0] modeB;
  logic       stepB;

  int checks;
  int failures;

  typedef struct {
    string      name;
    logic       en;
    logic [1:0] sw;
    int         clks;
    logic [2:0] expOut;
    logic [1:0] expMode;
    logic       expStep;
  } vec_t;

  vec_t vecs[32];
  int   nVecs;

  hazard_sequencer #(
    .TICK_DIV(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .sw1   (sw1),
    .sw0   (sw0),
    .out   (out),
    .mode  (mode),
    .step  (step)
  );

  hazard_sequencer #(
    .TICK_DIV(1)
  ) dutFast (
    .clk   (clk),
    .reset (resetB),
    .enable(enableB),
    .sw1   (sw1B),
    .sw0   (sw0B),
    .out   (outB),
    .mode  (modeB),
    .step  (stepB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison with reporting.
  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expOut,
                             input logic [1:0] expMode, input logic expStep);
    compare({name, ".out"},  {5'b0, out},  {5'b0, expOut});
    compare({name, ".mode"}, {6'b0, mode}, {6'b0, expMode});
    compare({name, ".step"}, {7'b0, step}, {7'b0, expStep});
  endtask

  task automatic checkFast(input string name, input logic [2:0] expOut,
                           input logic [1:0] expMode, input logic expStep);
    compare({name, ".out"},  {5'b0, outB},  {5'b0, expOut});
    compare({name, ".mode"}, {6'b0, modeB}, {6'b0, expMode});
    compare({name, ".step"}, {7'b0, stepB}, {7'b0, expStep});
  endtask

  // Drive one vector, then let the requested number of edges pass and settle.
  task automatic applyStimulus(input vec_t v);
    enable     = v.en;
    {sw1, sw0} = v.sw;
    repeat (v.clks) @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input string name, input logic en, input logic [1:0] sw,
                                 input int clks, input logic [2:0] expOut,
                                 input logic [1:0] expMode, input logic expStep);
    vecs[nVecs] = '{name, en, sw, clks, expOut, expMode, expStep};
    nVecs++;
  endfunction

  initial begin
    logic [2:0] fastPat[4];

    checks   = 0;
    failures = 0;
    nVecs    = 0;

    // Out of reset with sw=00: CALM alternates, a step every 4th clock.
    addVec("calm_first_step",  1'b1, 2'b00, 3, 3'b000, 2'b00, 1'b1);
    addVec("calm_c_a",         1'b1, 2'b00, 1, 3'b101, 2'b00, 1'b0);
    addVec("calm_step2",       1'b1, 2'b00, 3, 3'b101, 2'b00, 1'b1);
    addVec("calm_c_b",         1'b1, 2'b00, 1, 3'b010, 2'b00, 1'b0);
    addVec("calm_c_a2",        1'b1, 2'b00, 4, 3'b101, 2'b00, 1'b0);
    addVec("calm_c_b2",        1'b1, 2'b00, 4, 3'b010, 2'b00, 1'b0);
    // RIGHT, hold with 11, then jump to LEFT mid-sequence.
    addVec("right_r0",         1'b1, 2'b01, 4, 3'b100, 2'b01, 1'b0);
    addVec("right_r1",         1'b1, 2'b01, 4, 3'b010, 2'b01, 1'b0);
    addVec("keep_r2",          1'b1, 2'b11, 4, 3'b001, 2'b01, 1'b0);
    addVec("keep_r0",          1'b1, 2'b11, 4, 3'b100, 2'b01, 1'b0);
    addVec("right_r1b",        1'b1, 2'b01, 4, 3'b010, 2'b01, 1'b0);
    addVec("jump_left_l0",     1'b1, 2'b10, 4, 3'b001, 2'b10, 1'b0);
    addVec("left_l1",          1'b1, 2'b10, 4, 3'b010, 2'b10, 1'b0);
    // Freeze while counting, and drop enable exactly on a step cycle.
    addVec("pre_freeze",       1'b1, 2'b10, 2, 3'b010, 2'b10, 1'b0);
    addVec("frozen_10clk",     1'b0, 2'b10, 10, 3'b010, 2'b10, 1'b0);
    addVec("resume_step",      1'b1, 2'b10, 1, 3'b010, 2'b10, 1'b1);
    addVec("enable_drop_step", 1'b0, 2'b10, 0, 3'b010, 2'b10, 1'b0);
    addVec("frozen_on_step",   1'b0, 2'b10, 3, 3'b010, 2'b10, 1'b0);
    addVec("reenable_step",    1'b1, 2'b10, 0, 3'b010, 2'b10, 1'b1);
    addVec("left_l2",          1'b1, 2'b10, 1, 3'b100, 2'b10, 1'b0);
    addVec("left_wrap_l0",     1'b1, 2'b10, 4, 3'b001, 2'b10, 1'b0);
    // A switch change one clock before the step is not yet synchronised.
    addVec("sync_pre_step",    1'b1, 2'b10, 3, 3'b001, 2'b10, 1'b1);
    addVec("sync_too_late",    1'b1, 2'b01, 1, 3'b010, 2'b10, 1'b0);
    addVec("sync_right_r0",    1'b1, 2'b01, 4, 3'b100, 2'b01, 1'b0);
    addVec("mid_right",        1'b1, 2'b01, 2, 3'b100, 2'b01, 1'b0);

    reset   = 1'b0;
    enable  = 1'b1;
    sw1     = 1'b0;
    sw0     = 1'b0;
    resetB  = 1'b0;
    enableB = 1'b0;
    sw1B    = 1'b1;
    sw0B    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 3'b000, 2'b00, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < nVecs; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].expOut, vecs[i].expMode, vecs[i].expStep);
    end

    // Asynchronous reset mid-RIGHT, observed before any further clock edge.
    reset = 1'b0;
    #2;
    checkOutput("async_reset", 3'b000, 2'b00, 1'b0);

    // sw=11 straight out of reset resolves to CALM.
    sw1 = 1'b1;
    sw0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("keep_from_idle_step", 3'b000, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("keep_from_idle_calm", 3'b101, 2'b00, 1'b0);

    // TICK_DIV=1: held disabled until the switch request is synchronised.
    resetB = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkFast("fast_disabled", 3'b000, 2'b00, 1'b0);
    enableB = 1'b1;
    #1;
    checkFast("fast_step_on", 3'b000, 2'b00, 1'b1);
    fastPat[0] = 3'b001;
    fastPat[1] = 3'b010;
    fastPat[2] = 3'b100;
    fastPat[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkFast($sformatf("fast_left_%0d", i), fastPat[i], 2'b10, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
